// File: rtl/twiddle_gen.sv
`default_nettype none
// ============================================================================
//  Module      : twiddle_gen
//  Description : Streams the ordered radix-2 FFT twiddle sequence
//                W_N^e = cos(2*pi*e/N) - j*sin(2*pi*e/N), e = k << stage,
//                for one butterfly stage. Only a quarter-wave cosine table
//                of N/4+1 entries is held; the full half-circle is rebuilt
//                by quadrant fold plus sign/swap. Valid/ready output with
//                full backpressure through a 3-stage pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module twiddle_gen #(
    parameter int N       = 1024,
    parameter int DW      = 16,
    // Name of the hex image Q[i] = round(cos(2*pi*i/N)*(2^(DW-1)-1)).
    // The table below is elaborated from the same formula, so its content
    // is identical to that image and no file has to travel with the core.
    parameter     MEMFILE = "qcos.mem",
    localparam int LOG2N  = $clog2(N),
    localparam int SW     = $clog2(LOG2N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [SW-1:0]      stage,
    output logic               busy,
    output logic               done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      W_re,
    output logic [DW-1:0]      W_im,
    output logic [LOG2N-2:0]   out_idx,
    output logic               out_last
);

    // Widths: index/exponent k and e fit in LOG2N-1 bits (e < N/2),
    // table addresses must reach N/4 so they also need LOG2N-1 bits,
    // and the in-quadrant remainder needs LOG2N-2 bits.
    localparam int KW = LOG2N - 1;
    localparam int AW = LOG2N - 1;
    localparam int RW = LOG2N - 2;

    localparam logic [KW-1:0] C_KMAX      = KW'(N / 2 - 1);
    localparam logic [AW-1:0] C_QUARTER   = AW'(N / 4);
    localparam logic [SW:0]   C_LOG2N_EXT = (SW + 1)'(LOG2N);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Quarter-wave cosine table, elaborated with a Taylor series (x is
    // at most pi/2, so 14 terms are far below one LSB of error).
    // ------------------------------------------------------------------
    function automatic logic [DW-1:0] qcos_entry(input int idx);
        real x;
        real term;
        real sum;
        real scale;
        x     = 2.0 * 3.14159265358979323846 * real'(idx) / real'(N);
        term  = 1.0;
        sum   = 1.0;
        scale = real'((2 ** (DW - 1)) - 1);
        for (int n = 1; n <= 14; n++) begin
            term = -term * x * x / real'((2 * n - 1) * (2 * n));
            sum  = sum + term;
        end
        return DW'($rtoi(sum * scale + 0.5));
    endfunction

    logic [DW-1:0] qtab [0:N/4];

    for (genvar gi = 0; gi <= N / 4; gi++) begin : g_qtab
        assign qtab[gi] = qcos_entry(gi);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [SW-1:0]   s_q, s_d;
    logic            done_q, done_d;

    // stage 1: folded exponent
    logic            s1_valid_q, s1_valid_d;
    logic [KW-1:0]   s1_k_q, s1_k_d;
    logic            s1_quad_q, s1_quad_d;
    logic [AW-1:0]   s1_addr_a_q, s1_addr_a_d;
    logic [AW-1:0]   s1_addr_b_q, s1_addr_b_d;
    logic            s1_last_q, s1_last_d;

    // stage 2: table read
    logic            s2_valid_q, s2_valid_d;
    logic [KW-1:0]   s2_k_q, s2_k_d;
    logic            s2_quad_q, s2_quad_d;
    logic            s2_last_q, s2_last_d;
    logic [DW-1:0]   rom_a_q, rom_a_d;
    logic [DW-1:0]   rom_b_q, rom_b_d;

    // stage 3: output register
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   w_re_q, w_re_d;
    logic [DW-1:0]   w_im_q, w_im_d;
    logic [KW-1:0]   out_idx_q, out_idx_d;
    logic            out_last_q, out_last_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic            w_en;
    logic            w_issue;
    logic            w_stage_ok;
    logic [KW-1:0]   w_kmax;
    logic [KW-1:0]   w_e;
    logic [RW-1:0]   w_r;
    logic [DW-1:0]   w_neg_a;
    logic [DW-1:0]   w_neg_b;

    // Everything advances together unless a held word is being refused.
    assign w_en       = ~out_valid_q | out_ready;
    assign w_stage_ok = ({1'b0, stage} < C_LOG2N_EXT);
    // len-1 = (N/2 >> s) - 1 = (N/2 - 1) >> s because N/2 is a power of two.
    assign w_kmax     = C_KMAX >> s_q;
    // e < N/2, so bit LOG2N-2 of e is the quadrant and the rest is r.
    assign w_e        = k_q << s_q;
    assign w_r        = w_e[RW-1:0];
    assign w_neg_a    = -rom_a_q;
    assign w_neg_b    = -rom_b_q;

    // Sequence control: accept start, issue indices, wait for the last word.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        done_d  = 1'b0;
        w_issue = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && w_stage_ok) begin
                    state_d = ST_RUN;
                    s_d     = stage;
                    k_d     = '0;
                end
            end
            ST_RUN: begin
                if (w_en) begin
                    w_issue = 1'b1;
                    if (k_q == w_kmax) begin
                        state_d = ST_DRAIN;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pipeline: fold, table read, then sign/swap into the output register.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_k_d      = s1_k_q;
        s1_quad_d   = s1_quad_q;
        s1_addr_a_d = s1_addr_a_q;
        s1_addr_b_d = s1_addr_b_q;
        s1_last_d   = s1_last_q;
        s2_valid_d  = s2_valid_q;
        s2_k_d      = s2_k_q;
        s2_quad_d   = s2_quad_q;
        s2_last_d   = s2_last_q;
        rom_a_d     = rom_a_q;
        rom_b_d     = rom_b_q;
        out_valid_d = out_valid_q;
        w_re_d      = w_re_q;
        w_im_d      = w_im_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        if (w_en) begin
            s1_valid_d  = w_issue;
            s1_k_d      = k_q;
            s1_quad_d   = w_e[KW-1];
            s1_addr_a_d = {1'b0, w_r};
            s1_addr_b_d = C_QUARTER - {1'b0, w_r};
            s1_last_d   = (k_q == w_kmax);

            s2_valid_d  = s1_valid_q;
            s2_k_d      = s1_k_q;
            s2_quad_d   = s1_quad_q;
            s2_last_d   = s1_last_q;
            rom_a_d     = qtab[s1_addr_a_q];
            rom_b_d     = qtab[s1_addr_b_q];

            out_valid_d = s2_valid_q;
            // Bubbles leave the last word's fields in place.
            if (s2_valid_q) begin
                out_idx_d  = s2_k_q;
                out_last_d = s2_last_q;
                if (!s2_quad_q) begin
                    w_re_d = rom_a_q;
                    w_im_d = w_neg_b;
                end else begin
                    w_re_d = w_neg_b;
                    w_im_d = w_neg_a;
                end
            end
        end
    end

    // State and pipeline registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            s_q         <= '0;
            done_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_k_q      <= '0;
            s1_quad_q   <= 1'b0;
            s1_addr_a_q <= '0;
            s1_addr_b_q <= '0;
            s1_last_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_k_q      <= '0;
            s2_quad_q   <= 1'b0;
            s2_last_q   <= 1'b0;
            rom_a_q     <= '0;
            rom_b_q     <= '0;
            out_valid_q <= 1'b0;
            w_re_q      <= '0;
            w_im_q      <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            s_q         <= s_d;
            done_q      <= done_d;
            s1_valid_q  <= s1_valid_d;
            s1_k_q      <= s1_k_d;
            s1_quad_q   <= s1_quad_d;
            s1_addr_a_q <= s1_addr_a_d;
            s1_addr_b_q <= s1_addr_b_d;
            s1_last_q   <= s1_last_d;
            s2_valid_q  <= s2_valid_d;
            s2_k_q      <= s2_k_d;
            s2_quad_q   <= s2_quad_d;
            s2_last_q   <= s2_last_d;
            rom_a_q     <= rom_a_d;
            rom_b_q     <= rom_b_d;
            out_valid_q <= out_valid_d;
            w_re_q      <= w_re_d;
            w_im_q      <= w_im_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign W_re      = w_re_q;
    assign W_im      = w_im_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_twiddle_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_twiddle_gen
//  Description : Directed self-checking bench for twiddle_gen (N=16 main
//                instance, N=8 instance for the out-of-range stage case).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_twiddle_gen;

    logic        clk = 1'b0;
    logic        rst_n;

    // N=16 instance
    logic        start;
    logic [1:0]  stage;
    logic        busy, done, out_valid, out_ready, out_last;
    logic [15:0] W_re, W_im;
    logic [2:0]  out_idx;

    // N=8 instance
    logic        start8;
    logic [1:0]  stage8;
    logic        busy8, done8, out_valid8, out_ready8, out_last8;
    logic [15:0] W_re8, W_im8;
    logic [1:0]  out_idx8;

    int n_cmp  = 0;
    int n_fail = 0;

    // Stage-0 reference, indexed by exponent e (hand-computed, Q15 * 32767).
    int RE0 [8] = '{32767, 30273, 23170, 12539, 0, -12539, -23170, -30273};
    int IM0 [8] = '{0, -12539, -23170, -30273, -32767, -30273, -23170, -12539};

    twiddle_gen #(.N(16), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stage(stage),
        .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .W_re(W_re), .W_im(W_im), .out_idx(out_idx), .out_last(out_last)
    );

    twiddle_gen #(.N(8), .DW(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .stage(stage8),
        .busy(busy8), .done(done8), .out_valid(out_valid8), .out_ready(out_ready8),
        .W_re(W_re8), .W_im(W_im8), .out_idx(out_idx8), .out_last(out_last8)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one sequence; returns at the sample point in the cycle done=1.
    task automatic run_seq(input int stg, input int nw, input bit bp,
                           input bit inject, input string tag);
        int          idx;
        int          cyc;
        int          e;
        bit          pre_stall;
        logic [15:0] pre_re, pre_im;
        logic [2:0]  pre_idx;
        logic        pre_last;
        idx       = 0;
        pre_stall = 1'b0;
        pre_re    = '0;
        pre_im    = '0;
        pre_idx   = '0;
        pre_last  = 1'b0;
        start     = 1'b1;
        stage     = 2'(stg);
        step();
        start     = 1'b0;
        chk({tag, " busy_after_start"}, int'(busy), 1);
        for (cyc = 0; cyc < 300 && idx < nw; cyc++) begin
            if (bp)
                out_ready = ((cyc % 13) >= 5 && (cyc % 13) < 10) ? 1'b0
                            : ($urandom_range(0, 3) != 0);
            else
                out_ready = 1'b1;
            if (inject && (cyc == 4 || cyc == 5)) begin
                start = 1'b1;
                stage = 2'd1;
            end else begin
                start = 1'b0;
            end
            chk({tag, " busy_run"}, int'(busy), 1);
            if (pre_stall) begin
                chk({tag, " hold_re"}, int'(W_re), int'(pre_re));
                chk({tag, " hold_im"}, int'(W_im), int'(pre_im));
                chk({tag, " hold_idx_last"}, int'({out_idx, out_last}),
                    int'({pre_idx, pre_last}));
            end
            if (out_valid && idx == 0 && !bp)
                chk({tag, " first_latency"}, cyc, 3);
            if (out_valid && out_ready) begin
                e = idx << stg;
                chk({tag, " W_re"}, int'($signed(W_re)), RE0[e]);
                chk({tag, " W_im"}, int'($signed(W_im)), IM0[e]);
                chk({tag, " out_idx"}, int'(out_idx), idx);
                chk({tag, " out_last"}, int'(out_last), int'(idx == nw - 1));
                idx++;
            end
            pre_stall = out_valid && !out_ready;
            pre_re    = W_re;
            pre_im    = W_im;
            pre_idx   = out_idx;
            pre_last  = out_last;
            step();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        chk({tag, " word_count"}, idx, nw);
        chk({tag, " done_pulse"}, int'(done), 1);
        chk({tag, " busy_fall"}, int'(busy), 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        stage      = 2'd0;
        out_ready  = 1'b1;
        start8     = 1'b0;
        stage8     = 2'd0;
        out_ready8 = 1'b1;
        step();
        chk("reset_outputs", int'({busy, done, out_valid, out_last, W_re, W_im, out_idx}), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("idle_after_reset", int'({busy, done, out_valid}), 0);

        // Stage 0, out_ready held high
        run_seq(0, 8, 1'b0, 1'b0, "s0");
        step();
        chk("s0 done_one_cycle", int'(done), 0);

        // Stage 2 then stage 3 (single word)
        run_seq(2, 2, 1'b0, 1'b0, "s2");
        step();
        run_seq(3, 1, 1'b0, 1'b0, "s3");
        step();

        // Stage 0 with backpressure
        run_seq(0, 8, 1'b1, 1'b0, "bp");
        step();

        // Start pulses while busy must not disturb the stream
        run_seq(0, 8, 1'b0, 1'b1, "ign");

        // Back-to-back: start issued in the done cycle
        run_seq(2, 2, 1'b0, 1'b0, "b2b");
        step();
        chk("b2b idle", int'({busy, done, out_valid}), 0);

        // Out-of-range stage on N=8 (LOG2N=3): stage 3 is ignored
        start8 = 1'b1;
        stage8 = 2'd3;
        step();
        start8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bad_stage idle", int'({busy8, done8, out_valid8}), 0);
            step();
        end
        // Valid last stage on N=8: single word (32767, 0)
        start8 = 1'b1;
        stage8 = 2'd2;
        step();
        start8 = 1'b0;
        chk("n8 busy", int'(busy8), 1);
        step();
        step();
        step();
        chk("n8 valid", int'(out_valid8), 1);
        chk("n8 W_re", int'($signed(W_re8)), 32767);
        chk("n8 W_im", int'($signed(W_im8)), 0);
        chk("n8 idx_last", int'({out_idx8, out_last8}), 1);
        step();
        chk("n8 done", int'({done8, busy8, out_valid8}), 3'b100);

        // Asynchronous reset mid-stream
        start = 1'b1;
        stage = 2'd0;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("mid valid", int'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            int'({busy, done, out_valid, out_last, W_re, W_im, out_idx}), 0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_reset_quiet", int'({busy, done, out_valid}), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
